// File: rtl/btc_hash_sched.sv
// rtl/btc_hash_sched.sv - nonce sweep controller feeding an external SHA-256 compression core
// Optional feature macro: TARGET_MASK_EN adds target_mask and masks the hit test.
module btc_hash_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] midstate,
    input  logic [95:0]  tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
`ifdef TARGET_MASK_EN
    input  logic [31:0]  target_mask,
`endif
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         aborted,
    output logic [31:0]  found_nonce,
    output logic [255:0] hash_out,
    output logic         core_start,
    input  logic         core_rq,
    input  logic [3:0]   core_addr,
    output logic         core_rdy,
    output logic [31:0]  core_data,
    output logic [255:0] core_state_in,
    input  logic [255:0] core_state_out,
    input  logic         core_done
);

    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        S_IDLE, S_P1_GO, S_P1_RUN, S_P2_GO, S_P2_RUN, S_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [31:0]   nonce_end_q, nonce_end_d;
    logic          abort_q, abort_d;
    logic [255:0]  digest1_q, digest1_d;
    logic          found_q, found_d;
    logic          exhausted_q, exhausted_d;
    logic          aborted_q, aborted_d;
    logic [31:0]   found_nonce_q, found_nonce_d;
    logic [255:0]  hash_q, hash_d;
    logic          core_rdy_q, core_rdy_d;
    logic [31:0]   core_data_q, core_data_d;

    logic          pass2;
    logic          hit;
    logic          abort_pend;
    logic [31:0]   word;
    logic [255:0]  digest_shifted;

`ifdef TARGET_MASK_EN
    assign hit = (hash_q[31:0] & target_mask) == 32'h0;
`else
    assign hit = hash_q[31:0] == 32'h0;
`endif

    // An abort arriving in the same cycle as core_done takes effect immediately.
    assign abort_pend = abort_q | abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_P1_GO;
            S_P1_GO:  state_d = S_P1_RUN;
            S_P1_RUN: if (core_done) state_d = abort_pend ? S_IDLE : S_P2_GO;
            S_P2_GO:  state_d = S_P2_RUN;
            S_P2_RUN: if (core_done) state_d = S_CHECK;
            S_CHECK: begin
                if (hit || abort_pend || nonce_q == nonce_end_q) state_d = S_IDLE;
                else                                             state_d = S_P1_GO;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = state_q != S_IDLE;
        core_start    = (state_q == S_P1_GO) || (state_q == S_P2_GO);
        pass2         = (state_q == S_P2_GO) || (state_q == S_P2_RUN);
        core_state_in = pass2 ? SHA_IV : midstate;
    end

    always_comb begin
        digest_shifted = digest1_q << {core_addr[2:0], 5'b0};
        word = 32'h0;
        if (pass2) begin
            if (!core_addr[3])           word = digest_shifted[255:224];
            else if (core_addr == 4'd8)  word = 32'h80000000;
            else if (core_addr == 4'd15) word = 32'h00000100;
        end else begin
            case (core_addr)
                4'd0:    word = tail[95:64];
                4'd1:    word = tail[63:32];
                4'd2:    word = tail[31:0];
                4'd3:    word = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
                4'd4:    word = 32'h80000000;
                4'd15:   word = 32'h00000280;
                default: word = 32'h0;
            endcase
        end
    end

    always_comb begin
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        abort_d       = abort_q;
        digest1_d     = digest1_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        aborted_d     = aborted_q;
        found_nonce_d = found_nonce_q;
        hash_d        = hash_q;
        core_rdy_d    = core_rq && !core_rdy_q;
        core_data_d   = (core_rq && !core_rdy_q) ? word : core_data_q;

        if (busy && abort) abort_d = 1'b1;

        case (state_q)
            S_IDLE: if (start) begin
                nonce_d     = nonce_start;
                nonce_end_d = nonce_end;
                found_d     = 1'b0;
                exhausted_d = 1'b0;
                aborted_d   = 1'b0;
                abort_d     = 1'b0;
            end
            S_P1_RUN: if (core_done) begin
                digest1_d = core_state_out;
                if (abort_pend) begin
                    aborted_d = 1'b1;
                    abort_d   = 1'b0;
                end
            end
            S_P2_RUN: if (core_done) hash_d = core_state_out;
            S_CHECK: begin
                if (hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    abort_d       = 1'b0;
                end else if (abort_pend) begin
                    aborted_d = 1'b1;
                    abort_d   = 1'b0;
                end else if (nonce_q == nonce_end_q) begin
                    exhausted_d = 1'b1;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q       <= 32'h0;
            nonce_end_q   <= 32'h0;
            abort_q       <= 1'b0;
            digest1_q     <= 256'h0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            aborted_q     <= 1'b0;
            found_nonce_q <= 32'h0;
            hash_q        <= 256'h0;
            core_rdy_q    <= 1'b0;
            core_data_q   <= 32'h0;
        end else begin
            nonce_q       <= nonce_d;
            nonce_end_q   <= nonce_end_d;
            abort_q       <= abort_d;
            digest1_q     <= digest1_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            aborted_q     <= aborted_d;
            found_nonce_q <= found_nonce_d;
            hash_q        <= hash_d;
            core_rdy_q    <= core_rdy_d;
            core_data_q   <= core_data_d;
        end
    end

    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign aborted     = aborted_q;
    assign found_nonce = found_nonce_q;
    assign hash_out    = hash_q;
    assign core_rdy    = core_rdy_q;
    assign core_data   = core_data_q;

endmodule

// File: tb/tb_btc_hash_sched.sv
// tb/tb_btc_hash_sched.sv - bench for btc_hash_sched with a behavioural SHA-256 core
// Build with TARGET_MASK_EN defined to also exercise the masked hit test.
module tb_btc_hash_sched;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk, rst_n, start, abort;
    logic [255:0] midstate;
    logic [95:0]  tail;
    logic [31:0]  nonce_start, nonce_end, target_mask;
    logic         busy, found, exhausted, aborted;
    logic [31:0]  found_nonce;
    logic [255:0] hash_out;
    logic         core_start, core_rq, core_rdy, core_done;
    logic [3:0]   core_addr;
    logic [31:0]  core_data;
    logic [255:0] core_state_in, core_state_out;

    int total = 0;
    int bad = 0;
    int n_starts = 0;
    int since_done = 0;
    logic [255:0] last_p1 = '0;
    logic [31:0]  exp_nonce_q [$];
    logic [255:0] exp_hash_q [$];

    btc_hash_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .midstate(midstate), .tail(tail),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
`ifdef TARGET_MASK_EN
        .target_mask(target_mask),
`endif
        .busy(busy), .found(found), .exhausted(exhausted), .aborted(aborted),
        .found_nonce(found_nonce), .hash_out(hash_out),
        .core_start(core_start), .core_rq(core_rq), .core_addr(core_addr),
        .core_rdy(core_rdy), .core_data(core_data),
        .core_state_in(core_state_in), .core_state_out(core_state_out),
        .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + st[255:224], b + st[223:192], c + st[191:160], d + st[159:128],
                e + st[127:96],  f + st[95:64],   g + st[63:32],   h + st[31:0]};
    endfunction

    function automatic logic [255:0] dbl_sha(input logic [31:0] n);
        logic [255:0] d1;
        d1 = sha_compress(midstate, {tail, bswap(n), 32'h80000000, 320'h0, 32'h00000280});
        return sha_compress(SHA_IV, {d1, 32'h80000000, 192'h0, 32'h00000100});
    endfunction

    // Behavioural core: fetch 16 words, check the block it was handed, return the compression.
    task automatic core_step(output bit ok);
        @(posedge clk);
        #1;
        ok = rst_n;
    endtask

    task automatic run_block(output bit ok);
        logic [255:0] st, res;
        logic [511:0] blk;
        logic [31:0]  n;
        bit got;
        st  = core_state_in;
        blk = '0;
        for (int a = 0; a < 16; a++) begin
            core_step(ok);
            if (!ok) return;
            core_rq   = 1'b1;
            core_addr = 4'(a);
            got = 1'b0;
            for (int t = 0; t < 8; t++) begin
                core_step(ok);
                if (!ok) return;
                if (core_rdy) begin
                    got = 1'b1;
                    break;
                end
            end
            core_rq = 1'b0;
            if (!got) begin
                check_eq("rdy_timeout", 0, 1);
                ok = 1'b0;
                return;
            end
            blk[511 - 32*a -: 32] = core_data;
        end
        res = sha_compress(st, blk);
        if (blk[31:0] == 32'h00000280) begin
            check_eq("p1_state", st, midstate);
            if (exp_nonce_q.size() == 0) begin
                check_eq("unexpected_nonce", blk[415:384], 32'hx);
            end else begin
                n = exp_nonce_q.pop_front();
                check_eq("p1_block", blk, {tail, bswap(n), 32'h80000000, 320'h0, 32'h00000280});
            end
            last_p1 = res;
        end else begin
            check_eq("p2_state", st, SHA_IV);
            check_eq("p2_block", blk, {last_p1, 32'h80000000, 192'h0, 32'h00000100});
        end
        for (int t = 0; t < 3; t++) begin
            core_step(ok);
            if (!ok) return;
        end
        core_state_out = res;
        core_done = 1'b1;
        core_step(ok);
        core_done = 1'b0;
    endtask

    initial begin : core_model
        bit ok;
        core_rq = 1'b0;
        core_addr = 4'h0;
        core_done = 1'b0;
        core_state_out = '0;
        @(posedge clk);
        #1;
        forever begin
            if (!rst_n) begin
                core_rq = 1'b0;
                core_done = 1'b0;
                since_done = 0;
                core_step(ok);
            end else if (core_start) begin
                if (since_done > 0) check_eq("done_to_start_gap", since_done <= 2, 1);
                n_starts++;
                run_block(ok);
                since_done = ok ? 1 : 0;
            end else begin
                core_step(ok);
                if (!busy) since_done = 0;
                else if (since_done > 0) since_done++;
            end
        end
    end

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input int abort_at, input int poke_at);
        bit done;
        nonce_start = s;
        nonce_end = e;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("busy_on_start", busy, 1);
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start = (i == poke_at);
            if (i == poke_at) nonce_start = 32'h55;
            abort = (i == abort_at);
            step();
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!done) check_eq("sweep_timeout", 0, 1);
    endtask

    initial begin : main
        int s0;
        bit reached;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        nonce_start = '0;
        nonce_end = '0;
        target_mask = 32'hffffffff;
        tail = 96'h4b1e5e4a_29ab5f49_ffff001d;
        midstate = sha_compress(SHA_IV, {32'h01000000, 256'h0,
            32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
            32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa});

        repeat (3) step();
        check_eq("rst_flags", {busy, found, exhausted, aborted, core_start, core_rdy}, 6'b0);
        check_eq("rst_found_nonce", found_nonce, 0);
        check_eq("rst_hash_out", hash_out, 0);
        check_eq("rst_core_data", core_data, 0);
        rst_n = 1'b1;
        step();

        // Genesis block: the real nonce must hit.
        exp_nonce_q.push_back(32'h7c2bac1d);
        exp_hash_q.push_back(dbl_sha(32'h7c2bac1d));
        run_sweep(32'h7c2bac1d, 32'h7c2bac1d, -1, -1);
        check_eq("gen_flags", {found, exhausted, aborted, busy}, 4'b1000);
        check_eq("gen_found_nonce", found_nonce, 32'h7c2bac1d);
        check_eq("gen_hash_low", hash_out[31:0], 32'h0);
        check_eq("gen_hash", hash_out, exp_hash_q.pop_front());

        // Single miss: nonce 0.
        exp_nonce_q.push_back(32'h0);
        exp_hash_q.push_back(dbl_sha(32'h0));
        run_sweep(32'h0, 32'h0, -1, -1);
        check_eq("miss_flags", {found, exhausted, aborted}, 3'b010);
        check_eq("miss_hash", hash_out, exp_hash_q.pop_front());

        // Wrapping sweep with a start pulse while busy that must be ignored.
        s0 = n_starts;
        exp_nonce_q.push_back(32'hfffffffe);
        exp_nonce_q.push_back(32'hffffffff);
        exp_nonce_q.push_back(32'h00000000);
        exp_nonce_q.push_back(32'h00000001);
        exp_hash_q.push_back(dbl_sha(32'h00000001));
        run_sweep(32'hfffffffe, 32'h00000001, -1, 30);
        check_eq("wrap_flags", {found, exhausted, aborted}, 3'b010);
        check_eq("wrap_core_starts", n_starts - s0, 8);
        check_eq("wrap_nonces_left", exp_nonce_q.size(), 0);
        check_eq("wrap_hash", hash_out, exp_hash_q.pop_front());

        // Abort during pass 1: core finishes, nothing more is started.
        s0 = n_starts;
        exp_nonce_q.push_back(32'd100);
        run_sweep(32'd100, 32'd200, 10, -1);
        check_eq("abort_flags", {found, exhausted, aborted, busy}, 4'b0010);
        repeat (20) step();
        check_eq("abort_core_starts", n_starts - s0, 1);
        check_eq("abort_nonces_left", exp_nonce_q.size(), 0);

`ifdef TARGET_MASK_EN
        target_mask = 32'h0;
        exp_nonce_q.push_back(32'd10);
        run_sweep(32'd10, 32'd20, -1, -1);
        check_eq("mask_flags", {found, exhausted, aborted}, 3'b100);
        check_eq("mask_found_nonce", found_nonce, 32'd10);
        target_mask = 32'hffffffff;
`endif

        // Asynchronous reset while the core is working on pass 2.
        s0 = n_starts;
        exp_nonce_q.push_back(32'd300);
        nonce_start = 32'd300;
        nonce_end = 32'd400;
        start = 1'b1;
        step();
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (n_starts - s0 >= 2) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        check_eq("p2_reached", reached, 1);
        repeat (5) step();
        check_eq("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_flags", {busy, found, exhausted, aborted, core_start, core_rdy}, 6'b0);
        check_eq("arst_found_nonce", found_nonce, 0);
        check_eq("arst_hash_out", hash_out, 0);
        check_eq("arst_core_data", core_data, 0);
        step();
        rst_n = 1'b1;
        check_eq("arst_nonces_left", exp_nonce_q.size(), 0);
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btc_hash_sched.md
BTC_HASH_SCHED -- requirements
Module: btc_hash_sched

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic rising-edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  begin sweep; abort  in  1  stop sweep; midstate  in  256  SHA-256 state after header bytes 0-63; tail  in  96  header bytes 64-75 as three big-endian words; nonce_start  in  32; nonce_end  in  32.
REQ-003 SHALL have ports: busy  out  1; found  out  1  sticky hit flag; exhausted  out  1  sticky no-hit flag; aborted  out  1  sticky abort flag; found_nonce  out  32; hash_out  out  256  last double-SHA digest.
REQ-004 SHALL have core-side ports: core_start  out  1; core_rq  in  1; core_addr  in  4; core_rdy  out  1; core_data  out  32; core_state_in  out  256; core_state_out  in  256; core_done  in  1.

Function
REQ-005 SHALL implement states IDLE, P1_GO, P1_RUN, P2_GO, P2_RUN, CHECK.
REQ-006 IDLE: start=1 SHALL latch nonce <= nonce_start, clear found/exhausted/aborted, go P1_GO; start while busy SHALL be ignored.
REQ-007 P1_GO/P2_GO SHALL pulse core_start exactly one cycle, then go P1_RUN/P2_RUN.
REQ-008 Pass 1 words by core_addr: 0-2 = tail[95:64], tail[63:32], tail[31:0]; 3 = byte-swapped nonce; 4 = 32'h80000000; 5-14 = 0; 15 = 32'h00000280; core_state_in = midstate.
REQ-009 Pass 2 words: 0-7 = pass-1 digest H0..H7; 8 = 32'h80000000; 9-14 = 0; 15 = 32'h00000100; core_state_in = SHA-256 IV (6a09e667 ... 5be0cd19).
REQ-010 Word handshake: core_rq=1 and core_rdy=0 SHALL register core_data for core_addr and assert core_rdy the next cycle for exactly one cycle; core_data SHALL be stable while core_rdy=1.
REQ-011 core_done in P1_RUN SHALL capture core_state_out as pass-1 digest, go P2_GO; in P2_RUN SHALL capture into hash_out, go CHECK.
REQ-012 CHECK (one cycle): hit = hit condition (see Configuration); hit SHALL set found, found_nonce <= nonce, go IDLE.
REQ-013 CHECK no hit: nonce == nonce_end SHALL set exhausted, go IDLE; else nonce <= nonce+1 mod 2^32, go P1_GO.
REQ-014 Nonce wrap: nonce_start > nonce_end SHALL sweep through FFFFFFFF -> 00000000; nonce_start == nonce_end SHALL test exactly one nonce.
REQ-015 Hit and nonce == nonce_end in same CHECK SHALL report found only (exhausted=0).
REQ-016 abort SHALL be latched while busy; core is never interrupted; at next core_done controller SHALL set aborted, go IDLE, leave found/exhausted 0.
REQ-017 abort and a hit in the same CHECK SHALL report found (found wins).
REQ-018 busy SHALL be 1 in every state except IDLE; core_done outside P1_RUN/P2_RUN SHALL be ignored.
REQ-019 Controller overhead SHALL be at most 2 cycles from core_done to next core_start.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE; busy, found, exhausted, aborted, core_start, core_rdy = 0; found_nonce, hash_out, core_data = 0.
REQ-021 Reset mid-sweep SHALL discard all progress; the core SHALL be reset by the same rst_n.

Configuration
REQ-022 Macro TARGET_MASK_EN defined: extra input target_mask (32) SHALL exist; hit = (hash_out[31:0] & target_mask) == 0.
REQ-023 TARGET_MASK_EN undefined: no target_mask port; hit = hash_out[31:0] == 32'h0.

Verification
REQ-024 Genesis header midstate/tail, nonce_start=nonce_end=0x7C2BAC1D (W3=0x1DAC2B7C) -> found=1, found_nonce=0x7C2BAC1D, hash_out[31:0]=0.
REQ-025 Same header, nonce_start=nonce_end=0 -> exhausted=1, found=0, hash_out equals bench double-SHA model.
REQ-026 nonce_start=FFFFFFFE, nonce_end=00000001, no hit -> exactly 4 nonces tested (FFFFFFFE, FFFFFFFF, 0, 1), then exhausted=1.
REQ-027 abort pulsed mid-pass-1 -> core_done still observed, then aborted=1, busy=0, no further core_start.
REQ-028 TARGET_MASK_EN, target_mask=0, any nonce -> found=1 after first nonce; rst_n low during P2_RUN -> all outputs 0 same cycle.
